// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-requester memory-port arbiter.
// Holds the arbiter state enum, the requester-index type, the default
// width constants and a small index-to-one-hot helper.
package carp_mem_pkg;

  localparam int DEF_NUM_COL    = 4;
  localparam int DEF_COL_WIDTH  = 8;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_MAX_LOCK   = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Requester index: 0 selects r0, 1 selects r1.
  typedef logic req_idx_t;

  function automatic logic [1:0] idx_to_onehot(input req_idx_t idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the requester handshakes and the RAM-port signals of
// mem_port_arbiter.
//   rN_req_i/rN_lock_i/rN_strobe_i/rN_addr_i/rN_data_i : requester N access
//   rN_gnt_o/rN_rvalid_o/rN_rdata_o                    : grant and response
//   mem_en_o/mem_strobe_o/mem_addr_o/mem_data_o        : RAM port drive
//   mem_data_i                                          : RAM read data
// slave  : arbiter side.  master : requesters plus RAM side.
interface mem_port_arbiter_if
  import carp_mem_pkg::*;
#(
  parameter int NUM_COL    = DEF_NUM_COL,
  parameter int COL_WIDTH  = DEF_COL_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH
) ();

  logic                  r0_req_i;
  logic                  r0_lock_i;
  logic [NUM_COL-1:0]    r0_strobe_i;
  logic [ADDR_WIDTH-1:0] r0_addr_i;
  logic [DATA_WIDTH-1:0] r0_data_i;
  logic                  r0_gnt_o;
  logic                  r0_rvalid_o;
  logic [DATA_WIDTH-1:0] r0_rdata_o;

  logic                  r1_req_i;
  logic                  r1_lock_i;
  logic [NUM_COL-1:0]    r1_strobe_i;
  logic [ADDR_WIDTH-1:0] r1_addr_i;
  logic [DATA_WIDTH-1:0] r1_data_i;
  logic                  r1_gnt_o;
  logic                  r1_rvalid_o;
  logic [DATA_WIDTH-1:0] r1_rdata_o;

  logic                  mem_en_o;
  logic [NUM_COL-1:0]    mem_strobe_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_data_o;
  logic [DATA_WIDTH-1:0] mem_data_i;

  modport slave (
    input  r0_req_i, r0_lock_i, r0_strobe_i, r0_addr_i, r0_data_i,
    input  r1_req_i, r1_lock_i, r1_strobe_i, r1_addr_i, r1_data_i,
    input  mem_data_i,
    output r0_gnt_o, r0_rvalid_o, r0_rdata_o,
    output r1_gnt_o, r1_rvalid_o, r1_rdata_o,
    output mem_en_o, mem_strobe_o, mem_addr_o, mem_data_o
  );

  modport master (
    output r0_req_i, r0_lock_i, r0_strobe_i, r0_addr_i, r0_data_i,
    output r1_req_i, r1_lock_i, r1_strobe_i, r1_addr_i, r1_data_i,
    output mem_data_i,
    input  r0_gnt_o, r0_rvalid_o, r0_rdata_o,
    input  r1_gnt_o, r1_rvalid_o, r1_rdata_o,
    input  mem_en_o, mem_strobe_o, mem_addr_o, mem_data_o
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin selector.
//   i_req  : raw requests      i_mask : eligibility mask
//   i_last : most recently granted requester
//   o_gnt  : one-hot grant (zero when nothing eligible requests)
module rr_arb2
  import carp_mem_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic [1:0] i_mask,
  input  req_idx_t   i_last,
  output logic [1:0] o_gnt
);

  logic [1:0] w_elig;

  always_comb begin
    w_elig = i_req & i_mask;
    o_gnt  = w_elig;
    // On contention the requester not granted last wins.
    if (w_elig == 2'b11) begin
      o_gnt = i_last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates two requesters onto one port of a byte-write dual-port RAM
// (read-first, one-cycle registered read). Round-robin in IDLE; a grant
// with lock_i set parks the port on its owner for up to MAX_LOCK beats.
// Every granted access returns a response one cycle later to its owner.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   bus_if : requester handshakes and RAM port (slave modport)
module mem_port_arbiter
  import carp_mem_pkg::*;
#(
  parameter int NUM_COL    = DEF_NUM_COL,
  parameter int COL_WIDTH  = DEF_COL_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH,
  parameter int MAX_LOCK   = DEF_MAX_LOCK
) (
  input  logic                clk_i,
  input  logic                rst_i,
  mem_port_arbiter_if.slave   bus_if
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  arb_state_e            r_state, w_state_nxt;
  req_idx_t              r_owner, w_owner_nxt;
  req_idx_t              r_last, w_last_nxt;
  logic [CNT_W-1:0]      r_lock_cnt, w_lock_cnt_nxt;
  logic                  r_rsp_vld_p1;
  req_idx_t              r_rsp_id_p1;

  logic [1:0]            w_req, w_lock, w_mask, w_gnt;
  logic                  w_any_gnt;
  req_idx_t              w_gnt_idx;
  logic                  w_own_lock;
  logic [NUM_COL-1:0]    w_strobe_sel;
  logic [ADDR_WIDTH-1:0] w_addr_sel;
  logic [DATA_WIDTH-1:0] w_data_sel;

  assign w_req  = {bus_if.r1_req_i,  bus_if.r0_req_i};
  assign w_lock = {bus_if.r1_lock_i, bus_if.r0_lock_i};

  // Reset blocks every grant; a lock restricts eligibility to the owner.
  // After a MAX_LOCK release r_last points at the old owner, so the
  // round-robin already favours the other requester on the next cycle.
  always_comb begin
    w_mask = 2'b11;
    if (rst_i) begin
      w_mask = 2'b00;
    end else if (r_state == LOCKED) begin
      w_mask = idx_to_onehot(r_owner);
    end
  end

  rr_arb2 u_rr_arb2 (
    .i_req  (w_req),
    .i_mask (w_mask),
    .i_last (r_last),
    .o_gnt  (w_gnt)
  );

  assign w_any_gnt  = |w_gnt;
  assign w_gnt_idx  = w_gnt[1];
  assign w_own_lock = w_lock[r_owner];

  // r_lock_cnt counts locked grants already issued, including the entry
  // grant; a grant seen with MAX_LOCK-1 on the counter is the last one.
  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_last_nxt     = r_last;
    w_lock_cnt_nxt = r_lock_cnt;
    if (w_any_gnt) begin
      w_last_nxt = w_gnt_idx;
    end
    case (r_state)
      IDLE: begin
        if (w_any_gnt && w_lock[w_gnt_idx] && (MAX_LOCK > 1)) begin
          w_state_nxt    = LOCKED;
          w_owner_nxt    = w_gnt_idx;
          w_lock_cnt_nxt = CNT_W'(1);
        end
      end
      LOCKED: begin
        if (w_any_gnt) begin
          if ((r_lock_cnt >= CNT_W'(MAX_LOCK - 1)) || !w_own_lock) begin
            w_state_nxt    = IDLE;
            w_lock_cnt_nxt = '0;
          end else begin
            w_lock_cnt_nxt = r_lock_cnt + 1'b1;
          end
        end else if (!w_own_lock) begin
          w_state_nxt    = IDLE;
          w_lock_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt    = IDLE;
        w_lock_cnt_nxt = '0;
      end
    endcase
  end

  // Stage p0 -> p1: grant owner registered alongside the RAM read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      r_last       <= 1'b1;
      r_lock_cnt   <= '0;
      r_rsp_vld_p1 <= 1'b0;
      r_rsp_id_p1  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last       <= w_last_nxt;
      r_lock_cnt   <= w_lock_cnt_nxt;
      r_rsp_vld_p1 <= w_any_gnt;
      r_rsp_id_p1  <= w_gnt_idx;
    end
  end

  always_comb begin
    w_strobe_sel = '0;
    w_addr_sel   = bus_if.r0_addr_i;
    w_data_sel   = bus_if.r0_data_i;
    if (w_gnt[1]) begin
      w_strobe_sel = bus_if.r1_strobe_i;
      w_addr_sel   = bus_if.r1_addr_i;
      w_data_sel   = bus_if.r1_data_i;
    end else if (w_gnt[0]) begin
      w_strobe_sel = bus_if.r0_strobe_i;
    end
  end

  assign bus_if.mem_en_o     = w_any_gnt;
  assign bus_if.mem_strobe_o = w_strobe_sel;
  assign bus_if.mem_addr_o   = w_addr_sel;
  assign bus_if.mem_data_o   = w_data_sel;

  assign bus_if.r0_gnt_o = w_gnt[0];
  assign bus_if.r1_gnt_o = w_gnt[1];

  // Responses in flight across a reset are dropped.
  assign bus_if.r0_rvalid_o = r_rsp_vld_p1 & ~rst_i & (r_rsp_id_p1 == 1'b0);
  assign bus_if.r1_rvalid_o = r_rsp_vld_p1 & ~rst_i & (r_rsp_id_p1 == 1'b1);
  assign bus_if.r0_rdata_o  = bus_if.mem_data_i;
  assign bus_if.r1_rdata_o  = bus_if.mem_data_i;

endmodule
